// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg
// Shared definitions for the pulse stretcher slice:
//   state_t              - FSM states (IDLE, ON, OFF)
//   DEFAULT_ON_CYCLES    - default LED on time in clk cycles
//   DEFAULT_OFF_CYCLES   - default forced gap after each blink
//   DEFAULT_PEND_W       - default width of the pending-event counter
//   cnt_width()          - width of the shared ON/OFF down-counter
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam int DEFAULT_ON_CYCLES  = 65536;
    localparam int DEFAULT_OFF_CYCLES = 65536;
    localparam int DEFAULT_PEND_W     = 4;

    // One counter serves both phases, so it must hold max(ON,OFF)-1.
    // Clamped to at least one bit so 1-cycle phases still elaborate.
    function automatic int cnt_width(input int on_cycles, input int off_cycles);
        int longest;
        longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if
// Event-in / LED-out bundle of the pulse stretcher.
//   pulse_in - 1-cycle event strobes (driven by the event source)
//   led_out  - stretched, registered LED drive
//   busy     - stretcher is not idle
//   pending  - events queued but not yet shown
//   dropped  - sticky: an event was lost
// Modports: master = event source / observer, slave = stretcher.
interface pulse_stretcher_if #(
    parameter int PEND_W = 4
);
    logic              pulse_in;
    logic              led_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              dropped;

    modport master (
        output pulse_in,
        input  led_out,
        input  busy,
        input  pending,
        input  dropped
    );

    modport slave (
        input  pulse_in,
        output led_out,
        output busy,
        output pending,
        output dropped
    );
endinterface

// File: rtl/pulse_event_queue.sv
// pulse_event_queue
// Saturating up/down counter of events waiting to be blinked.
//   clk, rst - clock, synchronous active-high reset
//   inc      - one new event to queue
//   dec      - one queued event is being consumed
//   count    - number of queued events, saturates at 2**W-1
//   full     - count is at its maximum
//   dropped  - sticky: an inc arrived while full (no dec alongside)
// inc and dec together leave the count untouched, even when full, since
// the consumed slot makes room for the new event.
// Only compiled when PULSE_STRETCHER_QUEUE_EN is defined.
`ifdef PULSE_STRETCHER_QUEUE_EN
module pulse_event_queue #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         dropped
);

    localparam logic [W-1:0] COUNT_MAX = '1;

    logic [W-1:0] count_reg, count_next;
    logic         dropped_reg, dropped_next;

    always_comb begin
        count_next   = count_reg;
        dropped_next = dropped_reg;
        if (inc && !dec) begin
            if (count_reg == COUNT_MAX) begin
                dropped_next = 1'b1;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end else if (dec && !inc) begin
            if (count_reg != '0) begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg   <= '0;
            dropped_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            dropped_reg <= dropped_next;
        end
    end

    assign count   = count_reg;
    assign full    = (count_reg == COUNT_MAX);
    assign dropped = dropped_reg;

endmodule
`endif

// File: rtl/pulse_stretcher.sv
// pulse_stretcher
// Turns 1-cycle events into visible LED blinks: each event gives ON_CYCLES
// of led_out high followed by a forced OFF_CYCLES low gap.
//   clk, rst - clock, synchronous active-high reset
//   io       - pulse_stretcher_if.slave (pulse_in, led_out, busy,
//              pending, dropped)
// Parameters: ON_CYCLES, OFF_CYCLES (both >= 1), PEND_W.
// Build option PULSE_STRETCHER_QUEUE_EN: when defined, events that arrive
// while a blink is in progress are queued in pulse_event_queue; when
// undefined they are discarded (setting dropped) and pending reads 0.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
    parameter int OFF_CYCLES = DEFAULT_OFF_CYCLES,
    parameter int PEND_W     = DEFAULT_PEND_W
) (
    input  logic               clk,
    input  logic               rst,
    pulse_stretcher_if.slave   io
);

    localparam int            CW       = cnt_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          led_reg;
    logic          busy_reg;

    logic          cnt_zero;
    logic          pend_empty;
    logic          event_deferred;

    assign cnt_zero = (cnt_reg == '0);

    // An event cannot start a blink right now: either a blink is running,
    // or the gap is ending but older queued events take precedence.
    assign event_deferred = io.pulse_in &&
                            ((state_reg == ON) ||
                             ((state_reg == OFF) && !(cnt_zero && pend_empty)));

`ifdef PULSE_STRETCHER_QUEUE_EN
    logic              pend_take;
    logic [PEND_W-1:0] pend_count;
    logic              pend_full;
    logic              pend_dropped;

    // End of the gap with something queued: the next blink comes from the queue.
    assign pend_take = (state_reg == OFF) && cnt_zero && !pend_empty;

    pulse_event_queue #(
        .W (PEND_W)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .inc     (event_deferred),
        .dec     (pend_take),
        .count   (pend_count),
        .full    (pend_full),
        .dropped (pend_dropped)
    );

    assign pend_empty = (pend_count == '0);
    assign io.pending = pend_count;
    assign io.dropped = pend_dropped;
`else
    logic dropped_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            dropped_reg <= 1'b0;
        end else if (event_deferred) begin
            dropped_reg <= 1'b1;
        end
    end

    assign pend_empty = 1'b1;
    assign io.pending = '0;
    assign io.dropped = dropped_reg;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (io.pulse_in) begin
                    state_next = ON;
                    cnt_next   = ON_LOAD;
                end
            end
            ON: begin
                if (cnt_zero) begin
                    state_next = OFF;
                    cnt_next   = OFF_LOAD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            OFF: begin
                if (!cnt_zero) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (!pend_empty || io.pulse_in) begin
                    // Back-to-back blink with no IDLE cycle in between.
                    state_next = ON;
                    cnt_next   = ON_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // led_out and busy are decoded from the next state so they are
    // registered yet line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            led_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            led_reg   <= (state_next == ON);
            busy_reg  <= (state_next != IDLE);
        end
    end

    assign io.led_out = led_reg;
    assign io.busy    = busy_reg;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher
// Directed bench for pulse_stretcher with ON_CYCLES=4, OFF_CYCLES=3,
// PEND_W=2. Each test starts from a reset cycle; cycle n is the interval
// after clock edge n-1, so a pulse driven in cycle 0 lights the LED from
// cycle 1. Expected per-cycle outputs are hand-written bit masks
// (bit n = cycle n); masks differ when PULSE_STRETCHER_QUEUE_EN is defined.
module tb_pulse_stretcher;

    localparam int ON_C  = 4;
    localparam int OFF_C = 3;
    localparam int PW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pulse_stretcher_if #(.PEND_W(PW)) io ();

    pulse_stretcher #(
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .PEND_W     (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    typedef struct {
        int          tid;
        int          cyc;
        logic        led;
        logic        busy;
        logic [PW-1:0] pend;
        logic        drop;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string tname [0:7];

    // Monitor: every cycle the DUT presents its outputs; compare whenever
    // an expectation is waiting.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (io.led_out !== e.led || io.busy !== e.busy ||
                io.pending !== e.pend || io.dropped !== e.drop) begin
                errors++;
                $display("FAIL %s cycle %0d: got led=%b busy=%b pending=%0d dropped=%b, want led=%b busy=%b pending=%0d dropped=%b",
                         tname[e.tid], e.cyc, io.led_out, io.busy, io.pending, io.dropped,
                         e.led, e.busy, e.pend, e.drop);
            end else begin
                $display("ok   %s cycle %0d: led=%b busy=%b pending=%0d dropped=%b",
                         tname[e.tid], e.cyc, io.led_out, io.busy, io.pending, io.dropped);
            end
        end
    end

    // One reset cycle, then n checked cycles of stimulus.
    task automatic run_test(input int tid, input int n,
                            input logic [63:0] pulses, input logic [63:0] rsts,
                            input logic [63:0] led,    input logic [63:0] busy,
                            input logic [63:0] p0,     input logic [63:0] p1,
                            input logic [63:0] drp);
        exp_t e;
        rst         = 1'b1;
        io.pulse_in = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < n; c++) begin
            rst         = rsts[c];
            io.pulse_in = pulses[c];
            e.tid  = tid;
            e.cyc  = c;
            e.led  = led[c];
            e.busy = busy[c];
            e.pend = {p1[c], p0[c]};
            e.drop = drp[c];
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
        rst         = 1'b0;
        io.pulse_in = 1'b0;
    endtask

    initial begin
        tname[0] = "none";
        tname[1] = "single";
        tname[2] = "burst4";
        tname[3] = "saturate";
        tname[4] = "busy_pulse";
        tname[5] = "reset_mid_on";
        tname[6] = "back_to_back";
        tname[7] = "drain";
        io.pulse_in = 1'b0;

        // Single event: LED cycles 1-4, busy 1-7.
        run_test(1, 10, 64'h1, 64'h0, 64'h1E, 64'hFE, 64'h0, 64'h0, 64'h0);

        // Pulse exactly at the last OFF cycle restarts with no IDLE gap.
        run_test(6, 17, 64'h81, 64'h0, 64'hF1E, 64'h7FFE, 64'h0, 64'h0, 64'h0);

`ifdef PULSE_STRETCHER_QUEUE_EN
        // Pulse during ON is queued and shown as a second blink at cycle 8.
        run_test(4, 17, 64'h5, 64'h0, 64'hF1E, 64'h7FFE, 64'hF8, 64'h0, 64'h0);
        // Pulses 0,2,3,4: pending 1,2,3 then 2,1,0 at each restart.
        run_test(2, 31, 64'h1D, 64'h0, 64'h3C78F1E, 64'h1FFFFFFE,
                 64'h3F80E8, 64'h7FF0, 64'h0);
        // Extra pulse at 5 hits a full queue: dropped from cycle 6, sticky.
        run_test(3, 31, 64'h3D, 64'h0, 64'h3C78F1E, 64'h1FFFFFFE,
                 64'h3F80E8, 64'h7FF0, 64'h7FFFFFC0);
        // Reset at cycle 2 (with a pulse in the reset cycle) clears everything.
        run_test(5, 8, 64'h7, 64'h4, 64'h6, 64'h6, 64'h4, 64'h0, 64'h0);
`else
        // Pulse during ON is discarded: one blink, dropped from cycle 3.
        run_test(4, 17, 64'h5, 64'h0, 64'h1E, 64'hFE, 64'h0, 64'h0, 64'h1FFF8);
        run_test(2, 31, 64'h1D, 64'h0, 64'h1E, 64'hFE, 64'h0, 64'h0, 64'h7FFFFFF8);
        run_test(3, 31, 64'h3D, 64'h0, 64'h1E, 64'hFE, 64'h0, 64'h0, 64'h7FFFFFF8);
        // Reset clears the sticky dropped flag set at cycle 2.
        run_test(5, 8, 64'h7, 64'h4, 64'h6, 64'h6, 64'h0, 64'h0, 64'h4);
`endif

        // Let the monitor consume what is left, bounded.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d unchecked expectations, want 0", tname[7], exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
